// File: rtl/bus_arb_pkg.sv
// Shared register-bus constants for the bus_arb slice: default widths,
// FSM state encodings and the ack-type matcher.
package bus_arb_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Only the ack of the in-flight transaction type completes it.
  function automatic logic ack_match(input logic we, input logic rd_ack, input logic wr_ack);
    return we ? wr_ack : rd_ack;
  endfunction

endpackage

// File: rtl/bus_arb_rr.sv
// Two-way round-robin selector: on a tie, grant the requester not granted last.
module bus_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master register-bus arbiter, one transaction in flight at a time.
// Optional strobe-to-ack timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int DATA_WIDTH = BUS_DATA_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                  bus_clk,
  input  logic                  bus_reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic                  bus_re,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic                  bus_rd_ack,
  input  logic                  bus_wr_ack
);

  logic [1:0]                 state;
  logic                       sel;
  logic                       last;
  logic                       we_q;
  logic [1:0]                 req;
  logic [1:0]                 grant;
  logic [1:0]                 ack;
  logic [1:0]                 err;
  logic [1:0][DATA_WIDTH-1:0] rd;
  logic                       busy;
  logic                       hit;
  logic                       expire;

  assign req  = {m1_req, m0_req};
  assign busy = (state == ST_STROBE) || (state == ST_WAIT);
  assign hit  = busy && ack_match(we_q, bus_rd_ack, bus_wr_ack);

  bus_arb_rr u_rr (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  // cnt is 0 in the strobe cycle, so expiry lands TIMEOUT cycles after it.
  always_ff @(posedge bus_clk) begin
    if (bus_reset || !busy) cnt <= '0;
    else                    cnt <= cnt + 16'd1;
  end

  assign expire = busy && (cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
`endif

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state       <= ST_IDLE;
      sel         <= 1'b0;
      last        <= 1'b1;
      we_q        <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_re      <= 1'b0;
      bus_we      <= 1'b0;
      ack         <= '0;
      err         <= '0;
      rd          <= '0;
    end else begin
      bus_re <= 1'b0;
      bus_we <= 1'b0;
      ack    <= '0;
      err    <= '0;
      rd     <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            sel         <= grant[1];
            last        <= grant[1];
            we_q        <= grant[1] ? m1_we      : m0_we;
            bus_addr    <= grant[1] ? m1_addr    : m0_addr;
            bus_wr_data <= grant[1] ? m1_wr_data : m0_wr_data;
            bus_re      <= grant[1] ? !m1_we     : !m0_we;
            bus_we      <= grant[1] ? m1_we      : m0_we;
            state       <= ST_STROBE;
          end
        end
        ST_STROBE, ST_WAIT: begin
          if (hit) begin
            ack[sel] <= 1'b1;
            rd[sel]  <= we_q ? '0 : bus_rd_data;
            state    <= ST_DONE;
          end else if (expire) begin
            ack[sel] <= 1'b1;
            err[sel] <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m0_ack     = ack[0];
  assign m1_ack     = ack[1];
  assign m0_err     = err[0];
  assign m1_err     = err[1];
  assign m0_rd_data = rd[0];
  assign m1_rd_data = rd[1];

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb; acts as both masters and the slave, sampling on negedge.
// Covers the BUS_ARB_TIMEOUT_EN build when that macro is defined.
module tb_bus_arb;

  logic        clk = 1'b0;
  logic        bus_reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic [15:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_re, bus_we, bus_rd_ack, bus_wr_ack;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .bus_clk(clk), .bus_reset(bus_reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd_data(m1_rd_data),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_re(bus_re), .bus_we(bus_we),
    .bus_rd_data(bus_rd_data), .bus_rd_ack(bus_rd_ack), .bus_wr_ack(bus_wr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus_reset = 1'b1;
    step();
    step();
    bus_reset = 1'b0;
  endtask

  logic [15:0] wa [4];
  logic [31:0] wd [4];
  int          ord [4];
  int          we_cnt, ack_cnt;

  initial begin
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wr_data = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wr_data = 0;
    bus_rd_data = 0; bus_rd_ack = 0; bus_wr_ack = 0;
    do_reset();

    // reset state
    chk("rst_strobes", {30'd0, bus_re, bus_we}, 32'd0);
    chk("rst_addr", {16'd0, bus_addr}, 32'd0);
    chk("rst_wdata", bus_wr_data, 32'd0);
    chk("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    chk("rst_rdata", m0_rd_data | m1_rd_data, 32'd0);

    // m0 read, same-cycle slave ack
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
    step();
    chk("rd_strobe", {30'd0, bus_re, bus_we}, 32'd2);
    chk("rd_addr", {16'd0, bus_addr}, 32'h10);
    chk("rd_early_ack", {31'd0, m0_ack}, 32'd0);
    bus_rd_ack = 1; bus_rd_data = 32'h12345678;
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    chk("rd_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
    chk("rd_data", m0_rd_data, 32'h12345678);
    chk("rd_err", {31'd0, m0_err}, 32'd0);
    chk("rd_strobe_low", {30'd0, bus_re, bus_we}, 32'd0);
    m0_req = 0;
    step();
    chk("rd_ack_pulse", {31'd0, m0_ack}, 32'd0);

    // simultaneous writes after reset: m0 then m1
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wr_data = 32'hA5A5A5A5;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0200; m1_wr_data = 32'h5A5A5A5A;
    we_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      bus_wr_ack = bus_we;
      if (bus_we && we_cnt < 4) begin
        wa[we_cnt] = bus_addr; wd[we_cnt] = bus_wr_data;
      end
      if (bus_we) we_cnt++;
      if (m0_ack && ack_cnt < 4) begin ord[ack_cnt] = 0; ack_cnt++; m0_req = 0; end
      if (m1_ack && ack_cnt < 4) begin ord[ack_cnt] = 1; ack_cnt++; m1_req = 0; end
    end
    bus_wr_ack = 0;
    chk("wr_count", we_cnt, 2);
    chk("wr_acks", ack_cnt, 2);
    if (we_cnt >= 2 && ack_cnt >= 2) begin
      chk("wr0_addr", {16'd0, wa[0]}, 32'h100);
      chk("wr0_data", wd[0], 32'hA5A5A5A5);
      chk("wr1_addr", {16'd0, wa[1]}, 32'h200);
      chk("wr1_data", wd[1], 32'h5A5A5A5A);
      chk("wr_order0", ord[0], 0);
      chk("wr_order1", ord[1], 1);
    end

    // stray acks in IDLE
    bus_rd_ack = 1; bus_wr_ack = 1;
    step();
    step();
    chk("idle_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("idle_strobe", {30'd0, bus_re, bus_we}, 32'd0);
    bus_rd_ack = 0; bus_wr_ack = 0;

    // m1 read, ack 3 cycles after strobe, wrong-type ack ignored
    m1_req = 1; m1_we = 0; m1_addr = 16'h0040;
    step();
    chk("slow_strobe", {30'd0, bus_re, bus_we}, 32'd2);
    chk("slow_addr0", {16'd0, bus_addr}, 32'h40);
    step();
    chk("slow_strobe_off", {31'd0, bus_re}, 32'd0);
    chk("slow_addr1", {16'd0, bus_addr}, 32'h40);
    bus_wr_ack = 1;
    step();
    bus_wr_ack = 0;
    chk("slow_wrong_ack", {31'd0, m1_ack}, 32'd0);
    chk("slow_addr2", {16'd0, bus_addr}, 32'h40);
    step();
    chk("slow_addr3", {16'd0, bus_addr}, 32'h40);
    chk("slow_no_ack", {31'd0, m1_ack}, 32'd0);
    bus_rd_ack = 1; bus_rd_data = 32'hCAFEF00D;
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    chk("slow_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
    chk("slow_data", m1_rd_data, 32'hCAFEF00D);

    // back-to-back: m1 holds req, next is a write; drops req mid-transaction
    m1_we = 1; m1_addr = 16'h0044; m1_wr_data = 32'h00000011;
    step();
    chk("b2b_idle", {31'd0, bus_we}, 32'd0);
    step();
    chk("b2b_strobe", {30'd0, bus_re, bus_we}, 32'd1);
    chk("b2b_addr", {16'd0, bus_addr}, 32'h44);
    chk("b2b_wdata", bus_wr_data, 32'h11);
    bus_wr_ack = 1; m1_req = 0;
    step();
    bus_wr_ack = 0;
    chk("b2b_ack", {31'd0, m1_ack}, 32'd1);
    chk("b2b_rdata", m1_rd_data, 32'd0);
    step();

    // no ack from slave
    m1_req = 1; m1_we = 0; m1_addr = 16'h0080;
    step();
    chk("to_strobe", {31'd0, bus_re}, 32'd1);
`ifdef BUS_ARB_TIMEOUT_EN
    repeat (7) step();
    chk("to_early", {31'd0, m1_ack}, 32'd0);
    step();
    chk("to_ack", {30'd0, m1_ack, m1_err}, 32'd3);
    chk("to_rdata", m1_rd_data, 32'd0);
    m1_req = 0;
`else
    repeat (20) step();
    chk("wait_no_ack", {31'd0, m1_ack}, 32'd0);
    chk("wait_strobe", {30'd0, bus_re, bus_we}, 32'd0);
    bus_rd_ack = 1; bus_rd_data = 32'h00000BAD;
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    chk("wait_ack", {30'd0, m1_ack, m1_err}, 32'd2);
    chk("wait_rdata", m1_rd_data, 32'h0BAD);
    m1_req = 0;
`endif
    step();
    step();

    // reset while in WAIT, then late ack
    m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
    step();
    chk("ab_strobe", {31'd0, bus_re}, 32'd1);
    step();
    bus_reset = 1;
    step();
    bus_reset = 0; m0_req = 0;
    bus_rd_ack = 1; bus_rd_data = 32'h0000DEAD;
    chk("ab_strobe_low", {30'd0, bus_re, bus_we}, 32'd0);
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    chk("ab_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
    chk("ab_rdata", m0_rd_data, 32'd0);

    // tie after reset goes to m0, the following tie to m1
    m0_req = 1; m0_we = 0; m0_addr = 16'h0030;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0034;
    step();
    chk("tie0_strobe", {31'd0, bus_re}, 32'd1);
    chk("tie0_addr", {16'd0, bus_addr}, 32'h30);
    bus_rd_ack = 1; bus_rd_data = 32'd1;
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    chk("tie0_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
    step();
    step();
    chk("tie1_addr", {16'd0, bus_addr}, 32'h34);
    chk("tie1_strobe", {31'd0, bus_re}, 32'd1);
    bus_rd_ack = 1; bus_rd_data = 32'd2;
    step();
    bus_rd_ack = 0; bus_rd_data = 0;
    m0_req = 0; m1_req = 0;
    chk("tie1_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
    chk("tie1_data", m1_rd_data, 32'd2);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
